// File: rtl/pixel_binarizer_framer.sv
// -----------------------------------------------------------------------------
// pixel_binarizer_framer
//
// Front end ahead of cnn_classifier. It thresholds a raster stream of grayscale
// pixels to one bit each and assembles a 16x16 frame into a flat vector. The
// frame is then held behind a valid/ready handshake until downstream releases it.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous, active-high reset
//   pix_valid     in   pix_data valid this cycle
//   pix_ready     out  block accepts a pixel this cycle
//   pix_data      in   PIX_W unsigned grayscale pixel
//   pix_sof       in   marks the first pixel (row 0, col 0) of a frame
//   thresh        in   PIX_W threshold, sampled on an accepted SOF pixel
//   binary_image  out  N-bit frame, bit k = row*IMG_DIM + col
//   img_valid     out  binary_image holds a complete frame
//   img_ready     in   downstream releases the frame (honoured only in HOLD)
//   ones_count    out  number of 1 bits in the held frame
//   frame_err     out  one-cycle pulse on a mid-frame SOF resync
//
// Build option
//   BINARIZER_SOF_RESYNC_EN : when defined, an SOF in FILL abandons the
//   partial frame and restarts it, pulsing frame_err. When undefined, an SOF
//   in FILL is an ordinary data pixel and frame_err is tied low.
// -----------------------------------------------------------------------------
module pixel_binarizer_framer #(
  parameter  int PIX_W   = 8,
  parameter  int IMG_DIM = 16,
  localparam int N       = IMG_DIM * IMG_DIM,
  localparam int IDX_W   = $clog2(N),
  localparam int CNT_W   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] thresh,
  output logic [N-1:0]     binary_image,
  output logic             img_valid,
  input  logic             img_ready,
  output logic [CNT_W-1:0] ones_count,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [PIX_W-1:0] thr_q;
  logic             rdy_q;
  logic             accept;
  logic             sof_take;   // pixel starts a frame (IDLE SOF, or resync)
  logic             data_take;  // pixel is an ordinary in-frame pixel
  logic [PIX_W-1:0] thr_use;
  logic             pix_bit;

  // pix_ready is a registered flag so it stays low throughout reset and has
  // no combinational path from pix_valid or img_ready.
  assign pix_ready = rdy_q;
  assign img_valid = (state == S_HOLD);
  assign accept    = pix_valid && rdy_q;

  // The SOF pixel is compared against the live threshold; every later pixel
  // uses the copy latched on that SOF.
  assign thr_use = sof_take ? thresh : thr_q;
  assign pix_bit = (pix_data >= thr_use);

  // NOTE: every signal written in an always_comb gets a default at the top, so
  // no path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    sof_take  = 1'b0;
    data_take = 1'b0;
    case (state)
      S_IDLE: begin
        // Accepts without SOF are consumed and dropped.
        if (accept && pix_sof) begin
          sof_take = 1'b1;
          state_n  = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
`ifdef BINARIZER_SOF_RESYNC_EN
          if (pix_sof) begin
            sof_take = 1'b1;
          end else
`endif
          begin
            data_take = 1'b1;
            if (idx == LAST_IDX) state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (img_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rdy_q        <= 1'b0;
      idx          <= '0;
      thr_q        <= '0;
      ones_count   <= '0;
      // NOTE: the frame buffer is a plain register vector, not a RAM, so it
      // can be cleared by reset like any other flop.
      binary_image <= '0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != S_HOLD);
      if (sof_take) begin
        thr_q           <= thresh;
        binary_image[0] <= pix_bit;
        idx             <= IDX_W'(1);
        ones_count      <= CNT_W'(pix_bit);
      end else if (data_take) begin
        binary_image[idx] <= pix_bit;
        ones_count        <= ones_count + CNT_W'(pix_bit);
        // The terminal accept leaves FILL, so idx is cleared rather than wrapped.
        idx               <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
    end
  end

`ifdef BINARIZER_SOF_RESYNC_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= sof_take && (state == S_FILL);
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_binarizer_framer.sv
// -----------------------------------------------------------------------------
// tb_pixel_binarizer_framer
//
// Directed bench for pixel_binarizer_framer. Expected frames come from a small
// reference threshold model over the known stimulus patterns.
// -----------------------------------------------------------------------------
module tb_pixel_binarizer_framer;

  localparam int N = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic           pix_valid;
  logic           pix_ready;
  logic [7:0]     pix_data;
  logic           pix_sof;
  logic [7:0]     thresh;
  logic [N-1:0]   binary_image;
  logic           img_valid;
  logic           img_ready;
  logic [8:0]     ones_count;
  logic           frame_err;

  int total = 0;
  int bad   = 0;

  pixel_binarizer_framer dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .thresh       (thresh),
    .binary_image (binary_image),
    .img_valid    (img_valid),
    .img_ready    (img_ready),
    .ones_count   (ones_count),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Stimulus patterns: 0 ramp, 1 constant 200, 2 all 255 but pixel 100 = 0,
  // 3 pixels with k%3==0 at 10, others at 250.
  function automatic logic [7:0] pix_of(input int mode, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'd200;
      2:       return (k == 100) ? 8'd0 : 8'd255;
      default: return (k % 3 == 0) ? 8'd10 : 8'd250;
    endcase
  endfunction

  function automatic logic [N-1:0] model_img(input int mode, input logic [7:0] th);
    logic [N-1:0] img;
    for (int k = 0; k < N; k++) img[k] = (pix_of(mode, k) >= th);
    return img;
  endfunction

  // Present one pixel and wait (bounded) until it is accepted. Inputs change
  // 1 time unit after the rising edge, outputs are sampled at the same point.
  task automatic push(input logic [7:0] d, input logic sof, input logic [7:0] th);
    int guard;
    guard     = 0;
    pix_data  = d;
    pix_sof   = sof;
    thresh    = th;
    pix_valid = 1'b1;
    while (!pix_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", {255'd0, pix_ready}, {255'd0, 1'b1});
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Push pixels first..last-1 of a pattern. Only the SOF pixel carries the real
  // threshold; later pixels drive 0 so a design that failed to latch it shows up.
  task automatic send_range(input int mode, input logic [7:0] th, input int first, input int last);
    for (int k = first; k < last; k++)
      push(pix_of(mode, k), (k == 0), (k == 0) ? th : 8'd0);
  endtask

  // Full frame, checking img_valid stays low before the last pixel and rises
  // right after it.
  task automatic send_frame(input string tag, input int mode, input logic [7:0] th);
    logic [N-1:0] exp;
    exp = model_img(mode, th);
    send_range(mode, th, 0, N - 1);
    check({tag, "_valid_early"}, {255'd0, img_valid}, '0);
    send_range(mode, th, N - 1, N);
    check({tag, "_valid"}, {255'd0, img_valid}, {255'd0, 1'b1});
    check({tag, "_ready_low"}, {255'd0, pix_ready}, '0);
    check({tag, "_image"}, binary_image, exp);
    check({tag, "_ones"}, {247'd0, ones_count}, N'($countones(exp)));
  endtask

  task automatic release_frame(input string tag);
    img_ready = 1'b1;
    @(posedge clk);
    #1;
    img_ready = 1'b0;
    check({tag, "_valid_fall"}, {255'd0, img_valid}, '0);
    check({tag, "_ready_back"}, {255'd0, pix_ready}, {255'd0, 1'b1});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] exp;
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'd255;
    pix_sof   = 1'b1;
    thresh    = 8'd0;
    img_ready = 1'b0;

    // Reset held two cycles with pix_valid high.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {255'd0, pix_ready}, '0);
    check("rst_valid", {255'd0, img_valid}, '0);
    check("rst_image", binary_image, '0);
    check("rst_ones", {247'd0, ones_count}, '0);
    check("rst_err", {255'd0, frame_err}, '0);
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_ready", {255'd0, pix_ready}, {255'd0, 1'b1});

    // Ramp frame, threshold 128: upper half ones, boundary at pixel 128.
    send_frame("ramp", 0, 8'd128);
    exp = {{128{1'b1}}, {128{1'b0}}};
    check("ramp_image_const", binary_image, exp);

    // Backpressure: frame held while downstream stalls and pixels are offered.
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 8'd0;
    thresh    = 8'd255;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_ready", {255'd0, pix_ready}, '0);
      check("bp_image", binary_image, exp);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    release_frame("bp");

    // New frame right after release: constant 200 against 100.
    send_frame("after_bp", 1, 8'd100);
    release_frame("after_bp");

    // Stray pixels in IDLE are dropped, then an all-ones frame.
    for (int s = 0; s < 5; s++) push(8'd0, 1'b0, 8'd255);
    check("stray_valid", {255'd0, img_valid}, '0);
    check("stray_ready", {255'd0, pix_ready}, {255'd0, 1'b1});
    send_frame("stray", 1, 8'd100);
    check("stray_ones_full", {247'd0, ones_count}, N'(256));
    release_frame("stray");

    // Mid-frame SOF at pixel 100 with value 0, threshold 1.
    for (int k = 0; k < 100; k++) push(8'd255, (k == 0), 8'd1);
    push(8'd0, 1'b1, 8'd1);
`ifdef BINARIZER_SOF_RESYNC_EN
    check("resync_err_pulse", {255'd0, frame_err}, {255'd0, 1'b1});
    for (int k = 1; k < N; k++) begin
      if (k == N - 1) check("resync_valid_early", {255'd0, img_valid}, '0);
      push(8'd255, 1'b0, 8'd0);
      if (k == 1) check("resync_err_clear", {255'd0, frame_err}, '0);
    end
    exp = {{255{1'b1}}, 1'b0};
`else
    check("sof_mid_err", {255'd0, frame_err}, '0);
    for (int k = 101; k < N; k++) begin
      if (k == N - 1) check("sof_mid_valid_early", {255'd0, img_valid}, '0);
      push(8'd255, 1'b0, 8'd0);
    end
    exp = model_img(2, 8'd1);
    check("sof_mid_bit100", {255'd0, binary_image[100]}, '0);
`endif
    check("sof_mid_valid", {255'd0, img_valid}, {255'd0, 1'b1});
    check("sof_mid_image", binary_image, exp);
    check("sof_mid_ones", {247'd0, ones_count}, N'(255));
    release_frame("sof_mid");

    // Reset at pixel 50 discards the partial frame.
    send_range(0, 8'd0, 0, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", {255'd0, img_valid}, '0);
    check("midrst_image", binary_image, '0);
    check("midrst_ones", {247'd0, ones_count}, '0);
    check("midrst_ready", {255'd0, pix_ready}, {255'd0, 1'b1});
    send_frame("post_rst", 3, 8'd100);
    check("post_rst_ones_170", {247'd0, ones_count}, N'(170));
    release_frame("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_binarizer_framer.md
# pixel_binarizer_framer

Front-end stage ahead of `cnn_classifier`. It accepts a raster stream of grayscale pixels and thresholds each one to a single bit. It assembles one 16x16 frame into the flat `binary_image` vector the classifier consumes, then holds the frame with a valid/ready handshake until the downstream controller has finished with it.

## Interface
Parameters:
- `PIX_W`, 8: grayscale pixel width.
- `IMG_DIM`, 16: frame side length; `N = IMG_DIM*IMG_DIM` = 256 pixels per frame.

Ports:
- `clk` input, 1: the single clock; all logic on the rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `pix_valid` input, 1: `pix_data` is valid this cycle.
- `pix_ready` output, 1: the block accepts a pixel this cycle.
- `pix_data` input, `PIX_W`: grayscale pixel value, unsigned.
- `pix_sof` input, 1: qualifies a pixel as the first pixel (row 0, col 0) of a frame.
- `thresh` input, `PIX_W`: binarization threshold, sampled on an accepted SOF pixel.
- `binary_image` output, `N`: assembled frame; bit `k = row*IMG_DIM + col`.
- `img_valid` output, 1: `binary_image` holds a complete frame.
- `img_ready` input, 1: downstream releases the frame.
- `ones_count` output, `$clog2(N+1)` (9): number of 1 bits in the held frame.
- `frame_err` output, 1: one-cycle pulse on a mid-frame SOF resync; constant 0 without the macro.

## Operation
- An accept occurs on a cycle with `pix_valid && pix_ready`.
- Pixel bit = `pix_data >= thr`, unsigned compare.
  - For the SOF pixel, `thr` is the live `thresh`.
  - For all later pixels, `thr` is the value latched on the SOF accept.
- State machine:
  - **IDLE**:
    - `pix_ready` = 1.
    - An accept without `pix_sof` is consumed and dropped.
    - An accept with `pix_sof` latches `thresh`, writes bit 0, sets `idx` to 1 and `ones_count` to that bit, then goes to FILL.
  - **FILL**:
    - `pix_ready` = 1.
    - Each accept writes bit `idx`, adds the bit to `ones_count`, and increments `idx`.
    - The accept with `idx == N-1` goes to HOLD and clears `idx`.
    - `pix_sof` in FILL is governed by the Configuration section.
  - **HOLD**:
    - `pix_ready` = 0 and `img_valid` = 1.
    - `binary_image` and `ones_count` are frozen.
    - `img_ready` = 1 goes to IDLE.
- Write `binary_image` bits in place; contents are defined only while `img_valid` = 1.
- `idx` is 8-bit (`$clog2(N)`). It never wraps past N-1 because the terminal accept leaves FILL.
- Reset clears the following: state to IDLE, `idx`, `binary_image`, `ones_count`, and the latched threshold.
  - Reset mid-FILL or mid-HOLD discards the partial or held frame; nothing is emitted.

## Timing
- Reset values:
  - `binary_image` = 0, `ones_count` = 0, `img_valid` = 0, `frame_err` = 0.
  - `pix_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.
- `pix_ready`, `img_valid` and `frame_err` are decoded from registered state and registered flags only, with no combinational path from inputs.
- Latency: the last (256th) pixel is accepted at edge t; `img_valid` = 1 from t+1.
- Minimum frame period, with no stalls and `img_ready` tied high:
  - 256 accept cycles.
  - 1 HOLD cycle.
  - The next SOF can be accepted in IDLE the cycle after HOLD exits.
- `img_ready` is ignored outside HOLD.
- `img_valid` falls the cycle after `img_ready` is sampled high in HOLD.
- `pix_valid` gaps in FILL stall assembly indefinitely; `idx` holds.

## Configuration
- Macro `BINARIZER_SOF_RESYNC_EN` controls a SOF accept in FILL.
- Defined:
  - The partial frame is abandoned.
  - The pixel is treated exactly as an IDLE SOF accept: threshold re-latched, bit 0 written, `idx` = 1, `ones_count` restarted.
  - `frame_err` pulses high for the following cycle.
- Not defined:
  - `pix_sof` is ignored in FILL; the pixel is an ordinary data pixel at `idx`.
  - `frame_err` is tied to 0.

## Test plan
- Reset: hold `rst` 2 cycles with `pix_valid` = 1 -> `pix_ready` = 0, `img_valid` = 0, `binary_image` = 0, `ones_count` = 0; first cycle after release `pix_ready` = 1.
- Ramp frame: `thresh` = 128, pixels `k` = 0..255 back-to-back with SOF on k=0 -> `binary_image[127:0]` = 0, `[255:128]` all 1, `ones_count` = 128, `img_valid` rises the cycle after pixel 255.
- Backpressure: after a complete frame, hold `img_ready` = 0 for 10 cycles with `pix_valid` = 1 -> `pix_ready` = 0, `binary_image` stable. Pulse `img_ready` for 1 cycle -> `img_valid` = 0 and `pix_ready` = 1 the next cycle; that SOF starts a new frame.
- Stray pixels: 5 accepts in IDLE without SOF, then a full frame of value 200 with `thresh` = 100 -> the first 5 are dropped, all 256 bits are 1, `ones_count` = 256.
- Mid-frame SOF at pixel 100, value 0, `thresh` = 1:
  - With macro: `frame_err` pulses once; completion needs 255 further accepts.
  - Without macro: completion at the original pixel 255, and bit 100 = 0.
- Reset at pixel 50 of FILL -> IDLE, no `img_valid`; the next full frame assembles correctly from bit 0.
